// File: rtl/alu_result_fifo.sv
// Result buffer between an ALU and its consumer: DEPTH-entry FIFO of {flags, result}.
// Optional flag statistics counters are built when ALU_RESULT_STATS_EN is defined.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic                     in_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RESULT_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              udf_cnt,
  output logic [15:0]              err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [EW-1:0] out_data_r;

  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] in_word_s;
  logic [AW-1:0] wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [EW-1:0] head_nxt_s;

  assign push_s    = in_valid && in_ready_r;
  assign pop_s     = out_valid_r && out_ready;
  assign in_word_s = {in_error, in_underflow, in_overflow, in_result};

  // Next pointers, occupancy and the head word the output register will hold.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = {EW{1'b0}};
    if (push_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? {AW{1'b0}} : wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? {AW{1'b0}} : rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // The slot under the write pointer is free, so if it becomes the head it holds the new word.
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = {EW{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = in_word_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= in_word_s;
    end
  end

  // Pointer, occupancy and registered handshake/output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {EW{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != FULL_CNT);
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      out_data_r  <= head_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_data_r[WIDTH-1:0];
  assign out_flags  = out_data_r[EW-1:WIDTH];
  assign count      = count_r;

`ifdef ALU_RESULT_STATS_EN
  logic [15:0] ovf_cnt_r;
  logic [15:0] udf_cnt_r;
  logic [15:0] err_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic hit);
    if (hit && (cnt != 16'hFFFF)) begin
      sat_inc = cnt + 16'd1;
    end else begin
      sat_inc = cnt;
    end
  endfunction

  // Saturating flag event counters; clear has priority over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      ovf_cnt_r <= 16'd0;
      udf_cnt_r <= 16'd0;
      err_cnt_r <= 16'd0;
    end else if (push_s) begin
      ovf_cnt_r <= sat_inc(ovf_cnt_r, in_overflow);
      udf_cnt_r <= sat_inc(udf_cnt_r, in_underflow);
      err_cnt_r <= sat_inc(err_cnt_r, in_error);
    end
  end

  assign ovf_cnt = ovf_cnt_r;
  assign udf_cnt = udf_cnt_r;
  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic              in_overflow;
  logic              in_underflow;
  logic              in_error;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [2:0]        out_flags;
  logic [3:0]        count;
  logic              stats_clr;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0]       ovf_cnt;
  logic [15:0]       udf_cnt;
  logic [15:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH+2:0]  mq[$];
  bit                m_ready;
  int                m_ovf;
  int                m_udf;
  int                m_err;

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_underflow(in_underflow), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .count(count)
`ifdef ALU_RESULT_STATS_EN
    , .stats_clr(stats_clr), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int c, input logic hit);
    return (hit && c < 65535) ? c + 1 : c;
  endfunction

  // Apply this cycle's inputs to the model at the clock edge.
  task automatic model_update();
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_ready = 1'b0;
      m_ovf = 0; m_udf = 0; m_err = 0;
    end else begin
      do_push = in_valid && m_ready;
      do_pop  = (mq.size() > 0) && out_ready;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_error, in_underflow, in_overflow, in_result});
`ifdef ALU_RESULT_STATS_EN
      if (stats_clr) begin
        m_ovf = 0; m_udf = 0; m_err = 0;
      end else if (do_push) begin
        m_ovf = sat16(m_ovf, in_overflow);
        m_udf = sat16(m_udf, in_underflow);
        m_err = sat16(m_err, in_error);
      end
`endif
      m_ready = (mq.size() < DEPTH);
    end
  endtask

  task automatic compare_all();
    logic [WIDTH+2:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check_eq("in_ready", in_ready, m_ready);
    check_eq("out_valid", out_valid, mq.size() != 0);
    check_eq("count", count, mq.size());
    check_eq("out_result", out_result, head[WIDTH-1:0]);
    check_eq("out_flags", out_flags, head[WIDTH+2:WIDTH]);
`ifdef ALU_RESULT_STATS_EN
    check_eq("ovf_cnt", ovf_cnt, m_ovf);
    check_eq("udf_cnt", udf_cnt, m_udf);
    check_eq("err_cnt", err_cnt, m_err);
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare at the falling edge.
  task automatic drive(input logic rs, input logic v, input logic [WIDTH-1:0] r,
                       input logic [2:0] f, input logic ordy);
    rst = rs; in_valid = v; in_result = r;
    in_error = f[2]; in_underflow = f[1]; in_overflow = f[0];
    out_ready = ordy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'd0, 3'd0, 1'b0);
    drive(1'b1, 1'b1, 32'h1234_5678, 3'd7, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 3'd0, 1'b0);
  endtask

  initial begin
    stats_clr = 1'b0;
    @(negedge clk);

    // Reset state and ready one cycle after release
    drive(1'b1, 1'b0, 32'd0, 3'd0, 1'b0);
    check_eq("rst_count", count, 4'd0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_result", out_result, 32'd0);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 3'd5, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 3'd0, 1'b0);
    check_eq("ready_after_rst", in_ready, 1'b1);

    // Five pushes without draining: first value at the head
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 3'(i), 1'b0);
    check_eq("p5_count", count, 4'd5);
    check_eq("p5_valid", out_valid, 1'b1);
    check_eq("p5_head", out_result, 32'hA000_0000);
    check_eq("p5_flags", out_flags, 3'd0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 32'd0, 3'd0, 1'b1);

    // Fill, then offer an extra word while popping: no pass-through when full
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 3'd1, 1'b0);
    check_eq("full_count", count, 4'd8);
    check_eq("full_ready", in_ready, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_0BAD, 3'd7, 1'b1);
    check_eq("full_pop_count", count, 4'd7);
    check_eq("full_pop_head", out_result, 32'hB000_0001);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 32'd0, 3'd0, 1'b1);
    check_eq("drained_result", out_result, 32'd0);

    // Continuous streaming across pointer wrap keeps occupancy constant
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 3'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 32'hC100_0000 + 32'(i), 3'(i), 1'b1);
      check_eq("stream_count", count, 4'd3);
    end

    // Reset mid-operation discards entries and overrides the push
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 3'd4, 1'b0);
    drive(1'b1, 1'b1, 32'hD0D0_D0D0, 3'd3, 1'b1);
    check_eq("midrst_count", count, 4'd0);
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_result", out_result, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 3'd0, 1'b0);

`ifdef ALU_RESULT_STATS_EN
    // Flag counting and clear priority
    do_reset();
    drive(1'b0, 1'b1, 32'd1, 3'b001, 1'b0);
    drive(1'b0, 1'b1, 32'd2, 3'b001, 1'b0);
    drive(1'b0, 1'b1, 32'd3, 3'b100, 1'b0);
    drive(1'b0, 1'b1, 32'd4, 3'b000, 1'b0);
    check_eq("st_ovf", ovf_cnt, 16'd2);
    check_eq("st_udf", udf_cnt, 16'd0);
    check_eq("st_err", err_cnt, 16'd1);
    stats_clr = 1'b1;
    drive(1'b0, 1'b1, 32'd5, 3'b001, 1'b0);
    stats_clr = 1'b0;
    check_eq("st_clr_ovf", ovf_cnt, 16'd0);

    // Saturation
    do_reset();
    for (int i = 0; i < 65534; i++) drive(1'b0, 1'b1, 32'(i), 3'b001, 1'b1);
    check_eq("st_fffe", ovf_cnt, 16'hFFFE);
    drive(1'b0, 1'b1, 32'd7, 3'b001, 1'b1);
    drive(1'b0, 1'b1, 32'd8, 3'b001, 1'b1);
    check_eq("st_sat", ovf_cnt, 16'hFFFF);
`endif

    // Randomized traffic with occasional reset and stats clear
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stats_clr = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ^ (i[7] == 1'b1));
    end
    stats_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
